scoreboarded_register_file: RTL and testbench

SCOREBOARDED_REGISTER_FILE -- requirements
Module: scoreboarded_register_file

---
 rtl/rf_pkg.sv | 13 +
 rtl/rf_scoreboard.sv | 58 +++++
 rtl/scoreboarded_register_file.sv | 123 ++++++++++++
 tb/tb_scoreboarded_register_file.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared types and default sizing for the scoreboarded register file.
package rf_pkg;

  typedef enum logic {
    RF_IDLE     = 1'b0,
    RF_CLEARING = 1'b1
  } rf_state_e;

  localparam int RF_XLEN_DEFAULT     = 32;
  localparam int RF_DEPTH_DEFAULT    = 32;
  localparam int RF_NUM_READ_DEFAULT = 2;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit tracking for the register file: reservations set busy bits, and
// writebacks, flush, or the start of a clear sequence release them.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int DEPTH    = RF_DEPTH_DEFAULT,
  parameter int AW       = $clog2(DEPTH),
  parameter int ZERO_REG = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             idle_i,
  input  logic             clear_start_i,
  input  logic             flush_i,
  input  logic             rsv_valid_i,
  input  logic [AW-1:0]    rsv_addr_i,
  input  logic             wb_valid_i,
  input  logic [AW-1:0]    wb_addr_i,
  output logic [DEPTH-1:0] busy_o,
  output logic             rsv_ready_o
);

  logic [DEPTH-1:0] busy_q, busy_d;
  logic             wb_same_addr;
  logic             rsv_fire;

  assign wb_same_addr = wb_valid_i && (wb_addr_i == rsv_addr_i);
  assign rsv_ready_o  = idle_i && !flush_i && (!busy_q[rsv_addr_i] || wb_same_addr);
  assign rsv_fire     = rsv_valid_i && rsv_ready_o;

  // Priority, lowest to highest: writeback clear, reservation set, bulk clear.
  always_comb begin
    busy_d = busy_q;
    if (idle_i && wb_valid_i) begin
      busy_d[wb_addr_i] = 1'b0;
    end
    if (rsv_fire) begin
      busy_d[rsv_addr_i] = 1'b1;
    end
    if (flush_i || clear_start_i) begin
      busy_d = '0;
    end
    if (ZERO_REG != 0) begin
      busy_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/scoreboarded_register_file.sv
// Multi-read-port register file with writeback bypass, busy scoreboard and a
// sequential whole-file clear.
//   state       | meaning
//   RF_IDLE     | normal operation: writeback, bypass, reservations accepted
//   RF_CLEARING | zeroing one register per cycle at cnt_q; other requests ignored
module scoreboarded_register_file
  import rf_pkg::*;
#(
  parameter int XLEN     = RF_XLEN_DEFAULT,
  parameter int DEPTH    = RF_DEPTH_DEFAULT,
  parameter int NUM_READ = RF_NUM_READ_DEFAULT,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_READ*AW-1:0]   rd_addr_i,
  output logic [NUM_READ*XLEN-1:0] rd_data_o,
  output logic [NUM_READ-1:0]      rd_busy_o,
  input  logic                     rsv_valid_i,
  input  logic [AW-1:0]            rsv_addr_i,
  output logic                     rsv_ready_o,
  input  logic                     wb_valid_i,
  input  logic [AW-1:0]            wb_addr_i,
  input  logic [XLEN-1:0]          wb_data_i,
  input  logic                     flush_i,
  input  logic                     clear_req_i,
  output logic                     clear_busy_o
);

  rf_state_e        state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [XLEN-1:0]  regs_q [DEPTH];
  logic [DEPTH-1:0] busy;
  logic             idle;
  logic             clear_start;
  logic             wr_en;

  assign idle         = (state_q == RF_IDLE);
  assign clear_start  = idle && clear_req_i;
  assign clear_busy_o = (state_q == RF_CLEARING);
  assign wr_en        = idle && wb_valid_i && !((ZERO_REG != 0) && (wb_addr_i == '0));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RF_IDLE: begin
        if (clear_req_i) begin
          state_d = RF_CLEARING;
          cnt_d   = '0;
        end
      end
      RF_CLEARING: begin
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = RF_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = RF_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RF_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else if (state_q == RF_CLEARING) begin
      regs_q[cnt_q] <= '0;
    end else if (wr_en) begin
      regs_q[wb_addr_i] <= wb_data_i;
    end
  end

  rf_scoreboard #(
    .DEPTH    (DEPTH),
    .AW       (AW),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .idle_i        (idle),
    .clear_start_i (clear_start),
    .flush_i       (flush_i),
    .rsv_valid_i   (rsv_valid_i),
    .rsv_addr_i    (rsv_addr_i),
    .wb_valid_i    (wb_valid_i),
    .wb_addr_i     (wb_addr_i),
    .busy_o        (busy),
    .rsv_ready_o   (rsv_ready_o)
  );

  // Hardwired zero wins over bypass; bypass only while idle.
  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [AW-1:0] addr;
    logic          hit_zero;
    logic          hit_wb;

    assign addr     = rd_addr_i[k*AW +: AW];
    assign hit_zero = (ZERO_REG != 0) && (addr == '0);
    assign hit_wb   = idle && wb_valid_i && (wb_addr_i == addr);

    assign rd_data_o[k*XLEN +: XLEN] = hit_zero ? '0 : (hit_wb ? wb_data_i : regs_q[addr]);
    assign rd_busy_o[k]              = !hit_zero && !hit_wb && busy[addr];
  end

endmodule

// File: tb/tb_scoreboarded_register_file.sv
// Randomized self-checking bench for scoreboarded_register_file against a
// behavioural model of the register contents, busy set and clear sequence.
module tb_scoreboarded_register_file;

  localparam int XLEN = 32;
  localparam int DEPTH = 32;
  localparam int NR = 2;
  localparam int AW = 5;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic [NR*AW-1:0]  rd_addr_i = '0;
  logic [NR*XLEN-1:0] rd_data_o;
  logic [NR-1:0]     rd_busy_o;
  logic              rsv_valid_i = 1'b0;
  logic [AW-1:0]     rsv_addr_i = '0;
  logic              rsv_ready_o;
  logic              wb_valid_i = 1'b0;
  logic [AW-1:0]     wb_addr_i = '0;
  logic [XLEN-1:0]   wb_data_i = '0;
  logic              flush_i = 1'b0;
  logic              clear_req_i = 1'b0;
  logic              clear_busy_o;

  int tests_run = 0;
  int failures  = 0;

  // Model state
  logic [XLEN-1:0] m_regs [DEPTH];
  bit              m_busy [DEPTH];
  bit              m_clear;
  int              m_idx;

  scoreboarded_register_file dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .rd_addr_i    (rd_addr_i),
    .rd_data_o    (rd_data_o),
    .rd_busy_o    (rd_busy_o),
    .rsv_valid_i  (rsv_valid_i),
    .rsv_addr_i   (rsv_addr_i),
    .rsv_ready_o  (rsv_ready_o),
    .wb_valid_i   (wb_valid_i),
    .wb_addr_i    (wb_addr_i),
    .wb_data_i    (wb_data_i),
    .flush_i      (flush_i),
    .clear_req_i  (clear_req_i),
    .clear_busy_o (clear_busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_clear = 1'b0;
    m_idx   = 0;
  endtask

  function automatic logic [XLEN-1:0] exp_data(int a);
    if (a == 0) return '0;
    if (!m_clear && wb_valid_i && int'(wb_addr_i) == a) return wb_data_i;
    return m_regs[a];
  endfunction

  function automatic bit exp_busy(int a);
    if (a == 0) return 1'b0;
    if (!m_clear && wb_valid_i && int'(wb_addr_i) == a) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic bit exp_ready();
    int a;
    a = int'(rsv_addr_i);
    if (m_clear || flush_i) return 1'b0;
    return !m_busy[a] || (wb_valid_i && int'(wb_addr_i) == a);
  endfunction

  // Advance the model by one clock using the currently applied inputs.
  task automatic model_edge();
    bit ready;
    ready = exp_ready();
    if (!m_clear) begin
      if (wb_valid_i && wb_addr_i != 0) begin
        m_regs[wb_addr_i] = wb_data_i;
        m_busy[wb_addr_i] = 1'b0;
      end
      if (rsv_valid_i && ready && rsv_addr_i != 0) m_busy[rsv_addr_i] = 1'b1;
      if (flush_i || clear_req_i) for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
      if (clear_req_i) begin
        m_clear = 1'b1;
        m_idx   = 0;
      end
    end else begin
      m_regs[m_idx] = '0;
      if (flush_i) for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
      if (m_idx == DEPTH - 1) m_clear = 1'b0;
      else m_idx++;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    rsv_valid_i = 1'b0;
    wb_valid_i  = 1'b0;
    flush_i     = 1'b0;
    clear_req_i = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_ni = 1'b0;
    model_reset();
    #3;
    rd_addr_i = {5'd9, 5'd5};
    rsv_addr_i = 5'd4;
    #1;
    tests_run++;
    if (rd_data_o !== '0 || rd_busy_o !== '0 || rsv_ready_o !== 1'b1 || clear_busy_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: data=%h busy=%b ready=%b clr=%b, want 0 0 1 0",
               rd_data_o, rd_busy_o, rsv_ready_o, clear_busy_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_wb_read();
    wb_valid_i = 1'b1; wb_addr_i = 5'd5; wb_data_i = 32'hDEADBEEF;
    tick();
    wb_valid_i = 1'b0;
    rd_addr_i[0 +: AW] = 5'd5;
    #1;
    tests_run++;
    if (rd_data_o[0 +: XLEN] !== 32'hDEADBEEF || rd_busy_o[0] !== 1'b0) begin
      failures++;
      $display("FAIL wb_then_read: got %h busy %b, want deadbeef busy 0", rd_data_o[0 +: XLEN], rd_busy_o[0]);
    end
  endtask

  task automatic test_bypass();
    wb_valid_i = 1'b1; wb_addr_i = 5'd7; wb_data_i = 32'h12345678;
    rd_addr_i[AW +: AW] = 5'd7;
    #1;
    tests_run++;
    if (rd_data_o[XLEN +: XLEN] !== 32'h12345678 || rd_busy_o[1] !== 1'b0) begin
      failures++;
      $display("FAIL bypass: got %h busy %b, want 12345678 busy 0", rd_data_o[XLEN +: XLEN], rd_busy_o[1]);
    end
    tick();
    wb_valid_i = 1'b0;
  endtask

  task automatic test_reservation();
    rsv_valid_i = 1'b1; rsv_addr_i = 5'd3;
    tick();
    rd_addr_i = {5'd3, 5'd3};
    #1;
    tests_run++;
    if (rd_busy_o !== 2'b11) begin
      failures++;
      $display("FAIL rsv_busy: got %b, want 11", rd_busy_o);
    end
    tests_run++;
    if (rsv_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL rsv_waw_stall: ready %b, want 0", rsv_ready_o);
    end
    tick();
    rsv_valid_i = 1'b0;
    wb_valid_i = 1'b1; wb_addr_i = 5'd3; wb_data_i = 32'hA5;
    #1;
    tests_run++;
    if (rsv_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL rsv_ready_wb_same_cycle: ready %b, want 1", rsv_ready_o);
    end
    tick();
    wb_valid_i = 1'b0;
    #1;
    tests_run++;
    if (rd_busy_o !== 2'b00 || rsv_ready_o !== 1'b1 || rd_data_o[0 +: XLEN] !== 32'hA5) begin
      failures++;
      $display("FAIL rsv_released: busy %b ready %b data %h, want 00 1 a5", rd_busy_o, rsv_ready_o, rd_data_o[0 +: XLEN]);
    end
  endtask

  task automatic test_zero_reg();
    wb_valid_i = 1'b1; wb_addr_i = 5'd0; wb_data_i = 32'hFFFFFFFF;
    rd_addr_i = {5'd0, 5'd0};
    #1;
    tests_run++;
    if (rd_data_o !== '0) begin
      failures++;
      $display("FAIL zero_no_bypass: got %h, want 0", rd_data_o);
    end
    tick();
    wb_valid_i = 1'b0;
    rsv_valid_i = 1'b1; rsv_addr_i = 5'd0;
    tick();
    rsv_valid_i = 1'b0;
    #1;
    tests_run++;
    if (rd_data_o !== '0 || rd_busy_o !== 2'b00) begin
      failures++;
      $display("FAIL zero_reg: data %h busy %b, want 0 00", rd_data_o, rd_busy_o);
    end
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int n = 0; n < 400; n++) begin
      wb_valid_i  = ($urandom_range(0, 2) == 0);
      wb_addr_i   = AW'($urandom_range(0, 7));
      wb_data_i   = $urandom;
      rsv_valid_i = ($urandom_range(0, 1) == 0);
      rsv_addr_i  = AW'($urandom_range(0, 7));
      flush_i     = ($urandom_range(0, 19) == 0);
      rd_addr_i   = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
      #1;
      for (int k = 0; k < NR; k++) begin
        int a;
        a = int'(rd_addr_i[k*AW +: AW]);
        tests_run++;
        if (rd_data_o[k*XLEN +: XLEN] !== exp_data(a) || rd_busy_o[k] !== exp_busy(a)) begin
          failures++;
          errs++;
          if (errs < 10)
            $display("FAIL random_read p%0d a%0d: got %h/%b, want %h/%b", k, a,
                     rd_data_o[k*XLEN +: XLEN], rd_busy_o[k], exp_data(a), exp_busy(a));
        end
      end
      tests_run++;
      if (rsv_ready_o !== exp_ready()) begin
        failures++;
        errs++;
        if (errs < 10) $display("FAIL random_rsv_ready: got %b, want %b", rsv_ready_o, exp_ready());
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic fill_all();
    for (int i = 1; i < DEPTH; i++) begin
      wb_valid_i = 1'b1; wb_addr_i = AW'(i); wb_data_i = $urandom | 32'h1;
      rsv_valid_i = ($urandom_range(0, 1) == 0); rsv_addr_i = AW'($urandom_range(1, DEPTH - 1));
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_clear();
    int cycles;
    int errs;
    fill_all();
    clear_req_i = 1'b1;
    tick();
    clear_req_i = 1'b0;
    cycles = 0;
    errs = 0;
    while (clear_busy_o === 1'b1 && cycles < 100) begin
      wb_valid_i  = 1'b1; wb_addr_i = AW'($urandom_range(1, DEPTH - 1)); wb_data_i = $urandom;
      rsv_valid_i = 1'b1; rsv_addr_i = AW'($urandom_range(1, DEPTH - 1));
      clear_req_i = ($urandom_range(0, 3) == 0);
      rd_addr_i   = {AW'($urandom_range(0, DEPTH - 1)), wb_addr_i};
      #1;
      tests_run++;
      if (rsv_ready_o !== 1'b0 || rd_data_o[0 +: XLEN] !== exp_data(int'(rd_addr_i[0 +: AW]))
          || rd_data_o[XLEN +: XLEN] !== exp_data(int'(rd_addr_i[AW +: AW]))) begin
        failures++;
        errs++;
        if (errs < 10)
          $display("FAIL clearing_io: ready %b d0 %h d1 %h, want 0 %h %h", rsv_ready_o,
                   rd_data_o[0 +: XLEN], rd_data_o[XLEN +: XLEN],
                   exp_data(int'(rd_addr_i[0 +: AW])), exp_data(int'(rd_addr_i[AW +: AW])));
      end
      tick();
      cycles++;
    end
    idle_inputs();
    tests_run++;
    if (cycles != DEPTH) begin
      failures++;
      $display("FAIL clear_duration: %0d cycles, want %0d", cycles, DEPTH);
    end
    errs = 0;
    for (int i = 0; i < DEPTH; i += 2) begin
      rd_addr_i = {AW'(i + 1), AW'(i)};
      #1;
      tests_run++;
      if (rd_data_o !== '0 || rd_busy_o !== 2'b00) begin
        failures++;
        errs++;
        if (errs < 5) $display("FAIL after_clear a%0d: data %h busy %b, want 0 00", i, rd_data_o, rd_busy_o);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    fill_all();
    clear_req_i = 1'b1;
    tick();
    clear_req_i = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rd_addr_i = {5'd20, 5'd15};
    #1;
    tests_run++;
    if (rd_data_o[0 +: XLEN] !== m_regs[15] || clear_busy_o !== 1'b1) begin
      failures++;
      $display("FAIL mid_clear_state: d %h clr %b, want %h 1", rd_data_o[0 +: XLEN], clear_busy_o, m_regs[15]);
    end
    #1;
    rst_ni = 1'b0;
    model_reset();
    #1;
    rsv_addr_i = 5'd12;
    #1;
    tests_run++;
    if (rd_data_o !== '0 || rd_busy_o !== '0 || rsv_ready_o !== 1'b1 || clear_busy_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_clear: data %h busy %b ready %b clr %b, want 0 0 1 0",
               rd_data_o, rd_busy_o, rsv_ready_o, clear_busy_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    tick();
    tests_run++;
    if (clear_busy_o !== 1'b0 || rd_data_o !== '0) begin
      failures++;
      $display("FAIL idle_after_release: clr %b data %h, want 0 0", clear_busy_o, rd_data_o);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_wb_read();
    test_bypass();
    test_reservation();
    test_zero_reg();
    test_random();
    test_clear();
    test_random();
    test_reset_mid_clear();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
